// File: rtl/uart_tx_periph.sv
// rtl/uart_tx_periph.sv - memory-mapped 8N1 UART transmitter with TX FIFO
//
// Purpose:
//   Bus-attached UART transmitter. Bytes written to DATA are queued in a
//   FIFO and sent as 8N1 frames on tx at a runtime-programmable divisor.
//
// Ports:
//   clk        system clock, rising-edge active
//   resetn     asynchronous active-low reset
//   cs         block select from the address decoder
//   mem_addr   byte offset, bits [4:2] select DATA(0) / STATUS(1) / DIVISOR(2)
//   mem_wdata  write data
//   mem_wmask  byte-lane write enables; nonzero with cs means a write
//   mem_rstrb  read strobe; with cs means a read
//   d_out      registered read data, valid the cycle after the strobe
//   tx         serial output, idle high

module uart_tx_periph #(
  parameter logic [15:0] DIV_RESET  = 16'd104,
  parameter int          FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        cs,
  input  logic [4:0]  mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wmask,
  input  logic        mem_rstrb,
  output logic [31:0] d_out,
  output logic        tx
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;

  logic [7:0]      r_mem [FIFO_DEPTH];
  logic [AW-1:0]   r_wptr;
  logic [AW-1:0]   r_rptr;
  logic [LW-1:0]   r_level;
  logic            r_ovf;
  logic [15:0]     r_div;
  logic [15:0]     r_bit_div;
  logic [15:0]     r_baud;
  logic [2:0]      r_bitcnt;
  logic [7:0]      r_shift;
  logic            r_tx;
  logic [31:0]     r_dout;

  logic            w_wr;
  logic            w_rd;
  logic            w_sel_data;
  logic            w_sel_status;
  logic            w_sel_div;
  logic            w_full;
  logic            w_empty;
  logic            w_busy;
  logic            w_push_req;
  logic            w_push;
  logic            w_pop;
  logic            w_ovf_set;
  logic            w_ovf_clr;
  logic [15:0]     w_div_eff;
  logic [7:0]      w_head;
  logic            w_bit_end;
  logic            w_tx_nxt;
  logic [15:0]     w_baud_nxt;
  logic [2:0]      w_bitcnt_nxt;
  logic [7:0]      w_shift_nxt;
  logic [15:0]     w_bit_div_nxt;
  logic [31:0]     w_status;
  logic [31:0]     w_rdata;
  logic            w_unused;

  assign w_wr         = cs && (mem_wmask != 4'b0000);
  assign w_rd         = cs && mem_rstrb;
  assign w_sel_data   = (mem_addr[4:2] == 3'd0);
  assign w_sel_status = (mem_addr[4:2] == 3'd1);
  assign w_sel_div    = (mem_addr[4:2] == 3'd2);

  assign w_full    = (r_level == LW'(FIFO_DEPTH));
  assign w_empty   = (r_level == '0);
  assign w_busy    = (r_state != S_IDLE);
  assign w_head    = r_mem[r_rptr];
  assign w_div_eff = (r_div == 16'd0) ? 16'd1 : r_div;

  // A push into a full FIFO still fits if the transmitter frees a slot
  // on the same edge.
  assign w_push_req = w_wr && w_sel_data && mem_wmask[0];
  assign w_push     = w_push_req && (!w_full || w_pop);
  assign w_ovf_set  = w_push_req && w_full && !w_pop;
  assign w_ovf_clr  = w_wr && w_sel_status && mem_wmask[0] && mem_wdata[3];

  assign w_unused = ^{mem_addr[1:0], mem_wdata[31:16]};

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  assign w_bit_end = (r_baud == 16'd0);

  always_comb begin
    w_state_nxt   = r_state;
    w_pop         = 1'b0;
    w_tx_nxt      = r_tx;
    w_baud_nxt    = r_baud;
    w_bitcnt_nxt  = r_bitcnt;
    w_shift_nxt   = r_shift;
    w_bit_div_nxt = r_bit_div;
    case (r_state)
      S_IDLE: begin
        w_tx_nxt = 1'b1;
        if (!w_empty) begin
          w_pop         = 1'b1;
          w_shift_nxt   = w_head;
          w_bit_div_nxt = w_div_eff;
          w_baud_nxt    = w_div_eff - 16'd1;
          w_tx_nxt      = 1'b0;
          w_state_nxt   = S_START;
        end
      end
      S_START: begin
        if (w_bit_end) begin
          w_tx_nxt     = r_shift[0];
          w_baud_nxt   = r_bit_div - 16'd1;
          w_bitcnt_nxt = 3'd0;
          w_state_nxt  = S_DATA;
        end else begin
          w_baud_nxt = r_baud - 16'd1;
        end
      end
      S_DATA: begin
        if (w_bit_end) begin
          w_baud_nxt = r_bit_div - 16'd1;
          if (r_bitcnt == 3'd7) begin
            w_tx_nxt    = 1'b1;
            w_state_nxt = S_STOP;
          end else begin
            // The next bit is presented straight from the shifter so tx
            // changes exactly on the bit boundary.
            w_bitcnt_nxt = r_bitcnt + 3'd1;
            w_shift_nxt  = {1'b0, r_shift[7:1]};
            w_tx_nxt     = r_shift[1];
          end
        end else begin
          w_baud_nxt = r_baud - 16'd1;
        end
      end
      S_STOP: begin
        if (w_bit_end) begin
          w_bitcnt_nxt = 3'd0;
          if (!w_empty) begin
            w_pop         = 1'b1;
            w_shift_nxt   = w_head;
            w_bit_div_nxt = w_div_eff;
            w_baud_nxt    = w_div_eff - 16'd1;
            w_tx_nxt      = 1'b0;
            w_state_nxt   = S_START;
          end else begin
            w_baud_nxt  = 16'd0;
            w_state_nxt = S_IDLE;
          end
        end else begin
          w_baud_nxt = r_baud - 16'd1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_tx_nxt    = 1'b1;
      end
    endcase
  end

  // ------------------------------------------------------ shift datapath
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_tx      <= 1'b1;
      r_baud    <= 16'd0;
      r_bitcnt  <= 3'd0;
      r_shift   <= 8'd0;
      r_bit_div <= 16'd1;
    end else begin
      r_tx      <= w_tx_nxt;
      r_baud    <= w_baud_nxt;
      r_bitcnt  <= w_bitcnt_nxt;
      r_shift   <= w_shift_nxt;
      r_bit_div <= w_bit_div_nxt;
    end
  end

  // ---------------------------------------------------------------- FIFO
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= mem_wdata[7:0];
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + AW'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  // ----------------------------------------------------------- registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_ovf <= 1'b0;
      r_div <= DIV_RESET;
    end else begin
      // Overflow takes priority over a same-cycle clear.
      if (w_ovf_set) begin
        r_ovf <= 1'b1;
      end else if (w_ovf_clr) begin
        r_ovf <= 1'b0;
      end
      if (w_wr && w_sel_div) begin
        if (mem_wmask[0]) r_div[7:0]  <= mem_wdata[7:0];
        if (mem_wmask[1]) r_div[15:8] <= mem_wdata[15:8];
      end
    end
  end

  assign w_status = {23'h0, 5'(r_level), r_ovf, w_empty, w_full, w_busy};

  always_comb begin
    w_rdata = 32'h0;
    if (w_sel_status) begin
      w_rdata = w_status;
    end else if (w_sel_div) begin
      w_rdata = {16'h0, r_div};
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_dout <= 32'h0;
    end else if (w_rd) begin
      r_dout <= w_rdata;
    end
  end

  assign d_out = r_dout;
  assign tx    = r_tx;

endmodule

// File: tb/tb_uart_tx_periph.sv
// tb/tb_uart_tx_periph.sv - directed self-checking bench for uart_tx_periph

module tb_uart_tx_periph;

  localparam logic [4:0] A_DATA   = 5'h00;
  localparam logic [4:0] A_STATUS = 5'h04;
  localparam logic [4:0] A_DIV    = 5'h08;
  localparam logic [4:0] A_OTHER  = 5'h0C;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        cs = 1'b0;
  logic [4:0]  mem_addr = 5'h0;
  logic [31:0] mem_wdata = 32'h0;
  logic [3:0]  mem_wmask = 4'h0;
  logic        mem_rstrb = 1'b0;
  logic [31:0] d_out;
  logic        tx;

  int n_cmp  = 0;
  int n_fail = 0;

  logic cap[$];
  logic exp_q[$];

  uart_tx_periph #(
    .DIV_RESET (16'd104),
    .FIFO_DEPTH(8)
  ) dut (
    .clk      (clk),
    .resetn   (resetn),
    .cs       (cs),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_wmask(mem_wmask),
    .mem_rstrb(mem_rstrb),
    .d_out    (d_out),
    .tx       (tx)
  );

  always #5 clk = ~clk;

  // Bus tasks are entered 1 ns after a rising edge; the access is captured
  // on the next edge and the task returns 1 ns after it.
  task automatic bus_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] m);
    cs = 1'b1; mem_addr = a; mem_wdata = d; mem_wmask = m;
    @(posedge clk); #1;
    cs = 1'b0; mem_wmask = 4'h0;
  endtask

  task automatic bus_read(input logic [4:0] a, output logic [31:0] d);
    cs = 1'b1; mem_addr = a; mem_rstrb = 1'b1;
    @(posedge clk); #1;
    cs = 1'b0; mem_rstrb = 1'b0;
    d = d_out;
  endtask

  task automatic capture(input int n);
    cap.delete();
    for (int i = 0; i < n; i++) begin
      cap.push_back(tx);
      @(posedge clk); #1;
    end
  endtask

  // Expected tx samples for one 8N1 frame: start, 8 data bits LSB first, stop.
  task automatic build_frame(input logic [7:0] b, input int eff);
    for (int k = 0; k < 10; k++) begin
      for (int c = 0; c < eff; c++) begin
        if (k == 0)      exp_q.push_back(1'b0);
        else if (k == 9) exp_q.push_back(1'b1);
        else             exp_q.push_back(b[k-1]);
      end
    end
  endtask

  task automatic test_reset;
    logic [31:0] rd;
    n_cmp++;
    if (tx !== 1'b1) begin n_fail++; $display("FAIL reset_tx: got %b want 1", tx); end
    n_cmp++;
    if (d_out !== 32'h0) begin n_fail++; $display("FAIL reset_dout: got %h want 00000000", d_out); end
    resetn = 1'b1;
    bus_read(A_STATUS, rd);
    n_cmp++;
    if (rd !== 32'h0000_0004) begin n_fail++; $display("FAIL reset_status: got %h want 00000004", rd); end
    @(posedge clk); #1;
    n_cmp++;
    if (d_out !== 32'h0000_0004) begin n_fail++; $display("FAIL dout_hold: got %h want 00000004", d_out); end
    bus_read(A_DIV, rd);
    n_cmp++;
    if (rd !== 32'h0000_0068) begin n_fail++; $display("FAIL reset_div: got %h want 00000068", rd); end
  endtask

  task automatic test_registers;
    logic [31:0] rd;
    bus_write(A_DIV, 32'h0000_ABCD, 4'b0010);
    bus_read(A_DIV, rd);
    n_cmp++;
    if (rd !== 32'h0000_AB68) begin n_fail++; $display("FAIL div_hi_lane: got %h want 0000ab68", rd); end
    bus_write(A_DIV, 32'hFFFF_FF11, 4'b0001);
    bus_read(A_DIV, rd);
    n_cmp++;
    if (rd !== 32'h0000_AB11) begin n_fail++; $display("FAIL div_lo_lane: got %h want 0000ab11", rd); end
    bus_write(A_DATA, 32'h0000_0055, 4'b0010);
    bus_read(A_STATUS, rd);
    n_cmp++;
    if (rd !== 32'h0000_0004) begin n_fail++; $display("FAIL data_no_lane0: got %h want 00000004", rd); end
    bus_write(A_OTHER, 32'hFFFF_FFFF, 4'b1111);
    bus_read(A_OTHER, rd);
    n_cmp++;
    if (rd !== 32'h0) begin n_fail++; $display("FAIL other_offset: got %h want 00000000", rd); end
    n_cmp++;
    if (tx !== 1'b1) begin n_fail++; $display("FAIL regs_tx_idle: got %b want 1", tx); end
  endtask

  task automatic test_single_frame;
    logic [31:0] rd;
    bus_write(A_DIV, 32'h0000_0004, 4'b0011);
    bus_write(A_DATA, 32'h0000_00A5, 4'b0001);
    n_cmp++;
    if (tx !== 1'b1) begin n_fail++; $display("FAIL a5_pre_start: got %b want 1", tx); end
    @(posedge clk); #1;
    exp_q.delete();
    build_frame(8'hA5, 4);
    capture(40);
    for (int i = 0; i < 40; i++) begin
      n_cmp++;
      if (cap[i] !== exp_q[i]) begin n_fail++; $display("FAIL a5_frame[%0d]: got %b want %b", i, cap[i], exp_q[i]); end
    end
    n_cmp++;
    if (tx !== 1'b1) begin n_fail++; $display("FAIL a5_post_idle: got %b want 1", tx); end
    bus_read(A_STATUS, rd);
    n_cmp++;
    if (rd !== 32'h0000_0004) begin n_fail++; $display("FAIL a5_status_idle: got %h want 00000004", rd); end
  endtask

  task automatic test_back_to_back;
    logic [31:0] rd;
    bus_write(A_DIV, 32'h0000_0003, 4'b0011);
    bus_write(A_DATA, 32'h0000_003C, 4'b0001);
    bus_write(A_DATA, 32'h0000_00C3, 4'b0001);
    exp_q.delete();
    build_frame(8'h3C, 3);
    build_frame(8'hC3, 3);
    capture(60);
    for (int i = 0; i < 60; i++) begin
      n_cmp++;
      if (cap[i] !== exp_q[i]) begin n_fail++; $display("FAIL b2b_frame[%0d]: got %b want %b", i, cap[i], exp_q[i]); end
    end
    bus_read(A_STATUS, rd);
    n_cmp++;
    if (rd !== 32'h0000_0004) begin n_fail++; $display("FAIL b2b_status_idle: got %h want 00000004", rd); end
  endtask

  task automatic test_overflow;
    logic [31:0] rd;
    logic        done;
    int          lows;
    bus_write(A_DIV, 32'h0000_0002, 4'b0011);
    for (int i = 0; i < 9; i++) begin
      bus_write(A_DATA, 32'h0000_0010 + 32'(i), 4'b0001);
    end
    bus_read(A_STATUS, rd);
    n_cmp++;
    if (rd !== 32'h0000_0083) begin n_fail++; $display("FAIL ovf_full_status: got %h want 00000083", rd); end
    bus_write(A_DATA, 32'h0000_00EE, 4'b0001);
    bus_read(A_STATUS, rd);
    n_cmp++;
    if (rd !== 32'h0000_008B) begin n_fail++; $display("FAIL ovf_set_status: got %h want 0000008b", rd); end
    bus_write(A_STATUS, 32'h0000_0008, 4'b0001);
    bus_read(A_STATUS, rd);
    n_cmp++;
    if (rd !== 32'h0000_0083) begin n_fail++; $display("FAIL ovf_clear_status: got %h want 00000083", rd); end
    // The first frame ends 20 cycles after its pop; a push on that edge
    // meets a full FIFO that is popping and must be accepted.
    repeat (7) @(posedge clk);
    #1;
    bus_write(A_DATA, 32'h0000_0077, 4'b0001);
    bus_read(A_STATUS, rd);
    n_cmp++;
    if (rd !== 32'h0000_0083) begin n_fail++; $display("FAIL push_on_pop_status: got %h want 00000083", rd); end
    done = 1'b0;
    for (int i = 0; i < 400 && !done; i++) begin
      bus_read(A_STATUS, rd);
      if (rd == 32'h0000_0004) done = 1'b1;
    end
    n_cmp++;
    if (done !== 1'b1) begin n_fail++; $display("FAIL ovf_drain_timeout: status %h want 00000004", rd); end
    lows = 0;
    capture(30);
    for (int i = 0; i < 30; i++) if (cap[i] !== 1'b1) lows++;
    n_cmp++;
    if (lows !== 0) begin n_fail++; $display("FAIL ovf_no_extra_frame: low samples %0d want 0", lows); end
  endtask

  task automatic test_div_zero;
    bus_write(A_DIV, 32'h0000_0000, 4'b0011);
    bus_write(A_DATA, 32'h0000_0000, 4'b0001);
    bus_write(A_DATA, 32'h0000_005A, 4'b0001);
    n_cmp++;
    if (tx !== 1'b0) begin n_fail++; $display("FAIL div0_start: got %b want 0", tx); end
    bus_write(A_DIV, 32'h0000_0008, 4'b0011);
    exp_q.delete();
    build_frame(8'h00, 1);
    exp_q.delete(0);
    build_frame(8'h5A, 8);
    capture(89);
    for (int i = 0; i < 89; i++) begin
      n_cmp++;
      if (cap[i] !== exp_q[i]) begin n_fail++; $display("FAIL div0_then8[%0d]: got %b want %b", i, cap[i], exp_q[i]); end
    end
  endtask

  task automatic test_reset_mid_frame;
    logic [31:0] rd;
    int          lows;
    bus_write(A_DIV, 32'h0000_0004, 4'b0011);
    bus_write(A_DATA, 32'h0000_0000, 4'b0001);
    repeat (8) @(posedge clk);
    #1;
    n_cmp++;
    if (tx !== 1'b0) begin n_fail++; $display("FAIL mid_frame_low: got %b want 0", tx); end
    #2;
    resetn = 1'b0;
    #1;
    n_cmp++;
    if (tx !== 1'b1) begin n_fail++; $display("FAIL async_reset_tx: got %b want 1", tx); end
    n_cmp++;
    if (d_out !== 32'h0) begin n_fail++; $display("FAIL async_reset_dout: got %h want 00000000", d_out); end
    repeat (2) @(posedge clk);
    #1;
    resetn = 1'b1;
    bus_read(A_STATUS, rd);
    n_cmp++;
    if (rd !== 32'h0000_0004) begin n_fail++; $display("FAIL post_reset_status: got %h want 00000004", rd); end
    lows = 0;
    capture(50);
    for (int i = 0; i < 50; i++) if (cap[i] !== 1'b1) lows++;
    n_cmp++;
    if (lows !== 0) begin n_fail++; $display("FAIL residual_frame: low samples %0d want 0", lows); end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    test_registers();
    test_single_frame();
    test_back_to_back();
    test_overflow();
    test_div_zero();
    test_reset_mid_frame();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
